// File: rtl/key_event_decoder.sv
`default_nettype none
//============================================================================
// Module      : key_event_decoder
// Description : Turns a debounced key level into one-cycle gesture pulses:
//               short press, long press, double click and auto-repeat.
//               One shared counter times hold length, release gap and
//               repeat period.
// Revision    : 1.0 - initial release
//============================================================================
module key_event_decoder #(
    parameter int CNT_W      = 26,
    parameter int LONG_CNT   = 50_000_000,
    parameter int GAP_CNT    = 15_000_000,
    parameter int REPEAT_CNT = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic       short_press,
    output logic       long_press,
    output logic       double_click,
    output logic       repeat_tick,
    output logic       busy,
    output logic [1:0] last_event
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESS1    = 3'd1,
        ST_WAIT_GAP  = 3'd2,
        ST_LONG_HOLD = 3'd3,
        ST_PRESS2    = 3'd4
    } state_t;

    // Terminal counts: the counter starts at 0 on state entry, so the
    // transition edge is the one that sees N-1.
    localparam logic [CNT_W-1:0] C_LONG_TERM   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] C_GAP_TERM    = CNT_W'(GAP_CNT - 1);
    localparam logic [CNT_W-1:0] C_REPEAT_TERM = CNT_W'(REPEAT_CNT - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);

    localparam logic [1:0] C_EV_NONE   = 2'd0;
    localparam logic [1:0] C_EV_SHORT  = 2'd1;
    localparam logic [1:0] C_EV_LONG   = 2'd2;
    localparam logic [1:0] C_EV_DOUBLE = 2'd3;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_key_d;
    logic             r_short_press;
    logic             r_long_press;
    logic             r_double_click;
    logic             r_repeat_tick;
    logic [1:0]       r_last_event;
    logic             w_rise;

    // Press edge; key_d resets high so a key held through reset is ignored
    assign w_rise = key_in & ~r_key_d;

    // Gesture FSM with shared counter and registered event outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_key_d        <= 1'b1;
            r_short_press  <= 1'b0;
            r_long_press   <= 1'b0;
            r_double_click <= 1'b0;
            r_repeat_tick  <= 1'b0;
            r_last_event   <= C_EV_NONE;
        end else begin
            r_key_d        <= key_in;
            r_short_press  <= 1'b0;
            r_long_press   <= 1'b0;
            r_double_click <= 1'b0;
            r_repeat_tick  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state <= ST_PRESS1;
                        r_cnt   <= '0;
                    end
                end
                ST_PRESS1: begin
                    // Release takes priority over reaching the long count
                    if (!key_in) begin
                        r_state <= ST_WAIT_GAP;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_LONG_TERM) begin
                        r_state      <= ST_LONG_HOLD;
                        r_cnt        <= '0;
                        r_long_press <= 1'b1;
                        r_last_event <= C_EV_LONG;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end
                ST_LONG_HOLD: begin
                    if (!key_in) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_REPEAT_TERM) begin
                        r_cnt         <= '0;
                        r_repeat_tick <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end
                ST_WAIT_GAP: begin
                    // A second press beats the gap timeout
                    if (key_in) begin
                        r_state <= ST_PRESS2;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_GAP_TERM) begin
                        r_state       <= ST_IDLE;
                        r_cnt         <= '0;
                        r_short_press <= 1'b1;
                        r_last_event  <= C_EV_SHORT;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end
                ST_PRESS2: begin
                    if (!key_in) begin
                        r_state        <= ST_IDLE;
                        r_cnt          <= '0;
                        r_double_click <= 1'b1;
                        r_last_event   <= C_EV_DOUBLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign short_press  = r_short_press;
    assign long_press   = r_long_press;
    assign double_click = r_double_click;
    assign repeat_tick  = r_repeat_tick;
    assign last_event   = r_last_event;
    assign busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
//============================================================================
// Module      : tb_key_event_decoder
// Description : Directed, self-checking bench for key_event_decoder using
//               small timing parameters and hand-computed pulse edges.
// Revision    : 1.0 - initial release
//============================================================================
module tb_key_event_decoder;

    localparam int C_LONG   = 20;
    localparam int C_GAP    = 8;
    localparam int C_REPEAT = 5;

    logic       clk;
    logic       rst;
    logic       key_in;
    logic       short_press;
    logic       long_press;
    logic       double_click;
    logic       repeat_tick;
    logic       busy;
    logic [1:0] last_event;

    int n_vec  = 0;
    int n_miss = 0;

    // Pulse bookkeeping: edge index after which each pulse was seen
    int edge_no = 0;
    int n_short, n_long, n_double, n_repeat, n_multi;
    int e_short, e_long, e_double, e_rep_first, e_rep_last;
    int busy_at_short;

    key_event_decoder #(
        .CNT_W      (5),
        .LONG_CNT   (C_LONG),
        .GAP_CNT    (C_GAP),
        .REPEAT_CNT (C_REPEAT)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
        .repeat_tick  (repeat_tick),
        .busy         (busy),
        .last_event   (last_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count edges and sample pulses shortly after each rising edge
    always @(posedge clk) begin
        edge_no++;
        #1;
        if (short_press) begin
            n_short++;
            e_short       = edge_no;
            busy_at_short = int'(busy);
        end
        if (long_press) begin
            n_long++;
            e_long = edge_no;
        end
        if (double_click) begin
            n_double++;
            e_double = edge_no;
        end
        if (repeat_tick) begin
            if (n_repeat == 0) e_rep_first = edge_no;
            n_repeat++;
            e_rep_last = edge_no;
        end
        if (int'(short_press) + int'(long_press) + int'(double_click) + int'(repeat_tick) > 1)
            n_multi++;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_short = 0; n_long = 0; n_double = 0; n_repeat = 0; n_multi = 0;
        e_short = -1; e_long = -1; e_double = -1;
        e_rep_first = -1; e_rep_last = -1; busy_at_short = -1;
    endtask

    // Drive key at a falling edge; returns the index of the edge that samples it
    task automatic set_key(input logic v, output int e);
        @(negedge clk);
        key_in = v;
        e = edge_no + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, er, er2, dummy;
        clear_counts();
        rst    = 1'b1;
        key_in = 1'b1;

        // Reset held 3 cycles with the key pressed throughout
        idle(3);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_last", int'(last_event), 0);
        check_val("rst_pulses", int'(short_press) + int'(long_press)
                  + int'(double_click) + int'(repeat_tick), 0);
        rst = 1'b0;
        idle(25);
        check_val("hold_busy", int'(busy), 0);
        check_val("hold_last", int'(last_event), 0);
        check_val("hold_pulses", n_short + n_long + n_double + n_repeat, 0);
        set_key(1'b0, dummy);
        idle(3);
        check_val("rel_busy", int'(busy), 0);

        // Short press: 5 cycles held
        clear_counts();
        set_key(1'b1, e0);
        idle(1);
        check_val("sp_busy_on", int'(busy), 1);
        idle(3);
        set_key(1'b0, er);
        idle(12);
        check_val("sp_count", n_short, 1);
        check_val("sp_edge", e_short, er + C_GAP);
        check_val("sp_busy_fall", busy_at_short, 0);
        check_val("sp_last", int'(last_event), 1);
        check_val("sp_others", n_long + n_double + n_repeat, 0);

        // Long press with auto-repeat: held 36 cycles
        clear_counts();
        set_key(1'b1, e0);
        idle(35);
        set_key(1'b0, er);
        idle(12);
        check_val("lp_count", n_long, 1);
        check_val("lp_edge", e_long, e0 + C_LONG);
        check_val("rep_count", n_repeat, 3);
        check_val("rep_first", e_rep_first, e0 + C_LONG + C_REPEAT);
        check_val("rep_last", e_rep_last, e0 + C_LONG + 3 * C_REPEAT);
        check_val("lp_others", n_short + n_double, 0);
        check_val("lp_last", int'(last_event), 2);
        check_val("lp_busy_end", int'(busy), 0);

        // Double click: press 3, release 4, press 3, release
        clear_counts();
        set_key(1'b1, e0);
        idle(2);
        set_key(1'b0, er);
        idle(3);
        set_key(1'b1, dummy);
        idle(2);
        set_key(1'b0, er2);
        idle(12);
        check_val("dc_count", n_double, 1);
        check_val("dc_edge", e_double, er2);
        check_val("dc_short", n_short, 0);
        check_val("dc_last", int'(last_event), 3);

        // Release on the edge that sees cnt==LONG_CNT-1: no long press
        clear_counts();
        set_key(1'b1, e0);
        idle(C_LONG - 1);
        set_key(1'b0, er);
        idle(12);
        check_val("b1_rel_edge", er, e0 + C_LONG);
        check_val("b1_long", n_long, 0);
        check_val("b1_short", n_short, 1);
        check_val("b1_short_edge", e_short, er + C_GAP);
        check_val("b1_last", int'(last_event), 1);

        // Second press on the edge that sees cnt==GAP_CNT-1: double click wins
        clear_counts();
        set_key(1'b1, e0);
        idle(2);
        set_key(1'b0, er);
        idle(C_GAP - 1);
        set_key(1'b1, dummy);
        check_val("b2_press_edge", dummy, er + C_GAP);
        idle(2);
        set_key(1'b0, er2);
        idle(12);
        check_val("b2_short", n_short, 0);
        check_val("b2_double", n_double, 1);
        check_val("b2_double_edge", e_double, er2);
        check_val("b2_last", int'(last_event), 3);

        // Reset while waiting for a second press aborts silently
        clear_counts();
        set_key(1'b1, e0);
        idle(2);
        set_key(1'b0, er);
        idle(3);
        check_val("mr_busy_pre", int'(busy), 1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_val("mr_busy", int'(busy), 0);
        check_val("mr_last", int'(last_event), 0);
        idle(15);
        check_val("mr_short", n_short, 0);
        check_val("mr_pulses", n_long + n_double + n_repeat, 0);

        check_val("one_hot_pulses", n_multi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Consumes the debounced, active-high "key pressed" level from the key-debounce FSM.
- Classifies each press into one of four one-cycle event pulses: short press, long press, double click, and auto-repeat while held long.
- Feeds downstream mode/LED/counter control logic that needs gesture events rather than raw levels.
- One instance per key.

Parameters:
- CNT_W, 26, width of the shared timing counter; must hold max(LONG_CNT, GAP_CNT, REPEAT_CNT).
- LONG_CNT, 50_000_000, cycles the key must stay pressed to be a long press (1 s at 50 MHz); must be ≥2.
- GAP_CNT, 15_000_000, max release-to-second-press gap for a double click (300 ms); must be ≥2.
- REPEAT_CNT, 10_000_000, repeat pulse period while held after a long press (200 ms); must be ≥2.

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- rst, input, 1, synchronous active-high reset.
- key_in, input, 1, debounced key level; 1 = pressed.
- short_press, output, 1, one-cycle pulse: single short press confirmed.
- long_press, output, 1, one-cycle pulse: hold reached LONG_CNT.
- double_click, output, 1, one-cycle pulse: second press released.
- repeat_tick, output, 1, one-cycle pulse every REPEAT_CNT cycles while held after long_press.
- busy, output, 1, 1 whenever state ≠ IDLE (combinational from state register).
- last_event, output, 2, sticky code of the most recent event: 0 none, 1 short, 2 long, 3 double. repeat_tick does not change it.

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE, cnt=0, key_d=1, all pulse outputs=0, last_event=0, busy=0. Reset overrides everything, including mid-gesture; no event is emitted for an aborted gesture.
- key_d is set to 1 on reset so a key held through reset is ignored until it is released and pressed again.
- Input and counter:
  - key_d <= key_in every cycle.
  - rise = key_in & ~key_d, combinational.
  - cnt is the single shared counter. It is cleared on every state change and otherwise increments by 1 in PRESS1, WAIT_GAP and LONG_HOLD. It never wraps, because every terminal value forces a clear.
- All outputs except busy are registered. Each pulse is high exactly the one cycle after the edge that takes the corresponding transition; at all other times it is 0.
- States:
  - IDLE: rise → PRESS1, cnt<=0. Otherwise stay.
  - PRESS1:
    - key_in=0 → WAIT_GAP, cnt<=0.
    - Else if cnt==LONG_CNT-1 → LONG_HOLD, cnt<=0, long_press pulse, last_event<=2.
    - Else cnt++.
    - Release and terminal count in the same cycle: release wins (→ WAIT_GAP, no long_press).
  - LONG_HOLD:
    - key_in=0 → IDLE, no pulse.
    - Else if cnt==REPEAT_CNT-1 → repeat_tick pulse, cnt<=0.
    - Else cnt++.
  - WAIT_GAP:
    - key_in=1 → PRESS2, cnt<=0.
    - Else if cnt==GAP_CNT-1 → IDLE, short_press pulse, last_event<=1.
    - Else cnt++.
    - Press and timeout in the same cycle: press wins (double click path).
  - PRESS2: key_in=0 → IDLE, double_click pulse, last_event<=3. Hold length is ignored; there is no long press from PRESS2.
  - Unused encodings → IDLE, cnt<=0.
- Latencies (E0 = first edge sampling key_in=1 after key_in=0):
  - long_press is high in the cycle following edge E0+LONG_CNT.
  - short_press is high after edge Er+GAP_CNT, where Er = first edge sampling key_in=0.
  - double_click is high after the first edge sampling the second release.
- At most one pulse output is high in any cycle.

Test Plan:
- Reset hold: LONG_CNT=20, GAP_CNT=8, REPEAT_CNT=5. Assert rst for 3 cycles with key_in=1 held through reset, then release rst → no pulses, busy=0, last_event=0 until the key is released and re-pressed.
- Short press: press for 5 cycles, release → short_press high exactly 1 cycle, 8 edges after the release edge; last_event=1; busy falls the same cycle; no other pulse.
- Long press with repeat: hold for 36 cycles → long_press at E0+20; repeat_tick at E0+25, +30, +35; release → IDLE with no extra pulse; last_event=2.
- Double click: press 3, release 4, press 3, release → double_click 1 cycle after the second release edge; no short_press; last_event=3.
- Boundary cases:
  - Release at exactly cnt==19 in PRESS1 → no long_press; short_press follows 8 cycles later.
  - Second press landing on cnt==7 in WAIT_GAP → double-click path is taken.
- Mid-gesture reset: assert rst during WAIT_GAP → state IDLE, no short_press emitted, last_event returns to 0.
